updown_mod_counter: RTL and testbench

Parametrised successor of the single-digit clock counter. Counts up or down between MIN_CNT and a runtime-adjustable upper limit, with synchronous load for time-setting, carry/borrow outputs for cascading, and a registered wrap pulse. It sits in the configurable digital clock datapath as the seconds, minutes, hours, day or month stage. Instances chain carry_out or borrow_out into the next stage's en.

---
 rtl/updown_mod_counter.sv | 132 +++++++++++++
 tb/tb_updown_mod_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with runtime limit, load, carry/borrow and registered wrap pulse.
// Optional BCD outputs of the count are enabled by defining COUNTER_BCD_OUT_EN.
module updown_mod_counter #(
    parameter int WIDTH   = 6,
    parameter int MIN_CNT = 0,
    parameter int MAX_CNT = 59,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] cnt,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             wrapped
`ifdef COUNTER_BCD_OUT_EN
    ,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones
`endif
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_CNT);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_CNT);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

    generate
        if (RST_VAL < MIN_CNT || RST_VAL > MAX_CNT) begin : g_bad_rst_val
            $error("updown_mod_counter: RST_VAL outside MIN_CNT..MAX_CNT");
        end
    endgenerate

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] lo,
                                               input logic [WIDTH-1:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    logic             lim_ok;
    logic [WIDTH-1:0] eff_max;
    logic [WIDTH-1:0] cnt_nxt;
    logic             at_min;

    // A zero floor makes the lower-bound test trivially true, so it is dropped.
    generate
        if (MIN_CNT == 0) begin : g_lim_chk_zero
            assign lim_ok = !(lim > MAX_W);
        end else begin : g_lim_chk
            assign lim_ok = !(lim < MIN_W) && !(lim > MAX_W);
        end
    endgenerate

    assign eff_max = lim_ok ? lim : MAX_W;
    assign at_min  = !(cnt > MIN_W);

    always_comb begin
        cnt_nxt    = cnt;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        if (load) begin
            cnt_nxt = clamp(load_val, MIN_W, eff_max);
        end else if (en) begin
            if (up_dn) begin
                if (cnt >= eff_max) begin
                    cnt_nxt   = MIN_W;
                    carry_out = 1'b1;
                end else begin
                    cnt_nxt = cnt + WIDTH'(1);
                end
            end else if (at_min) begin
                cnt_nxt    = eff_max;
                borrow_out = 1'b1;
            end else if (cnt > eff_max) begin
                // Limit was lowered under us: pull back into range without a borrow.
                cnt_nxt = eff_max;
            end else begin
                cnt_nxt = cnt - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= RST_W;
            wrapped <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            wrapped <= carry_out | borrow_out;
        end
    end

`ifdef COUNTER_BCD_OUT_EN
    generate
        if (MAX_CNT > 99) begin : g_bad_bcd_range
            $error("updown_mod_counter: BCD outputs need MAX_CNT <= 99");
        end
    endgenerate

    function automatic logic [7:0] to_bcd(input logic [WIDTH-1:0] v);
        int vi;
        vi = int'(v);
        return {4'(vi / 10), 4'(vi % 10)};
    endfunction

    logic [7:0] bcd_nxt;
    logic [7:0] bcd_rst;

    assign bcd_nxt = to_bcd(cnt_nxt);
    assign bcd_rst = to_bcd(RST_W);

    // Converted from the next-state value so the digits land with cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_tens <= bcd_rst[7:4];
            bcd_ones <= bcd_rst[3:0];
        end else begin
            bcd_tens <= bcd_nxt[7:4];
            bcd_ones <= bcd_nxt[3:0];
        end
    end
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomized and directed bench for updown_mod_counter: a default 0..59 instance and a 1..31 day-style instance.
module tb_updown_mod_counter;

    logic       clk;
    logic       rst;

    logic       en_a, up_a, load_a;
    logic [5:0] lv_a, lim_a, cnt_a;
    logic       carry_a, borrow_a, wrapped_a;

    logic       en_b, up_b, load_b;
    logic [5:0] lv_b, lim_b, cnt_b;
    logic       carry_b, borrow_b, wrapped_b;

`ifdef COUNTER_BCD_OUT_EN
    logic [3:0] tens_a, ones_a, tens_b, ones_b;
`endif

    int checks;
    int failures;

    // Reference state: expected count and expected wrapped flag per instance.
    int ma, mb;
    bit mwa, mwb;

    updown_mod_counter #(.WIDTH(6), .MIN_CNT(0), .MAX_CNT(59), .RST_VAL(0)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .up_dn(up_a), .load(load_a),
        .load_val(lv_a), .lim(lim_a), .cnt(cnt_a), .carry_out(carry_a),
        .borrow_out(borrow_a), .wrapped(wrapped_a)
`ifdef COUNTER_BCD_OUT_EN
        , .bcd_tens(tens_a), .bcd_ones(ones_a)
`endif
    );

    updown_mod_counter #(.WIDTH(6), .MIN_CNT(1), .MAX_CNT(31), .RST_VAL(1)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .up_dn(up_b), .load(load_b),
        .load_val(lv_b), .lim(lim_b), .cnt(cnt_b), .carry_out(carry_b),
        .borrow_out(borrow_b), .wrapped(wrapped_b)
`ifdef COUNTER_BCD_OUT_EN
        , .bcd_tens(tens_b), .bcd_ones(ones_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int eff(int l, int mn, int mx);
        return (l >= mn && l <= mx) ? l : mx;
    endfunction

    function automatic int mnext(int c, bit e, bit u, bit ld, int lv, int l, int mn, int mx);
        int em;
        em = eff(l, mn, mx);
        if (ld) return (lv < mn) ? mn : ((lv > em) ? em : lv);
        if (!e) return c;
        if (u) return (c >= em) ? mn : c + 1;
        if (c <= mn) return em;
        if (c > em) return em;
        return c - 1;
    endfunction

    function automatic bit mcarry(int c, bit e, bit u, bit ld, int l, int mn, int mx);
        return e && u && !ld && (c >= eff(l, mn, mx));
    endfunction

    function automatic bit mborrow(int c, bit e, bit u, bit ld, int mn);
        return e && !u && !ld && (c <= mn);
    endfunction

    // Advance one clock and move the reference model with it.
    task automatic tick();
        int na, nb;
        bit wa, wb;
        wa = mcarry(ma, en_a, up_a, load_a, lim_a, 0, 59) || mborrow(ma, en_a, up_a, load_a, 0);
        wb = mcarry(mb, en_b, up_b, load_b, lim_b, 1, 31) || mborrow(mb, en_b, up_b, load_b, 1);
        na = mnext(ma, en_a, up_a, load_a, lv_a, lim_a, 0, 59);
        nb = mnext(mb, en_b, up_b, load_b, lv_b, lim_b, 1, 31);
        @(posedge clk);
        #1;
        ma = na; mwa = wa;
        mb = nb; mwb = wb;
    endtask

    task automatic idle_inputs();
        en_a = 0; up_a = 1; load_a = 0; lv_a = 0; lim_a = 6'd59;
        en_b = 0; up_b = 1; load_b = 0; lv_b = 0; lim_b = 6'd31;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (cnt_a !== 6'd0) begin failures++; $display("FAIL reset_cnt_a got=%0d exp=0", cnt_a); end
        checks++; if (cnt_b !== 6'd1) begin failures++; $display("FAIL reset_cnt_b got=%0d exp=1", cnt_b); end
        checks++; if (wrapped_a !== 1'b0 || wrapped_b !== 1'b0) begin failures++; $display("FAIL reset_wrapped got=%b%b exp=00", wrapped_a, wrapped_b); end
        checks++; if (carry_a !== 1'b0 || borrow_a !== 1'b0) begin failures++; $display("FAIL reset_carry_borrow got=%b%b exp=00", carry_a, borrow_a); end
`ifdef COUNTER_BCD_OUT_EN
        checks++; if (tens_b !== 4'd0 || ones_b !== 4'd1) begin failures++; $display("FAIL reset_bcd_b got=%0d/%0d exp=0/1", tens_b, ones_b); end
`endif
        rst = 1'b0;
        ma = 0; mwa = 0; mb = 1; mwb = 0;
    endtask

    task automatic test_count_up_wrap();
        idle_inputs();
        en_a = 1; up_a = 1;
        for (int i = 0; i < 62; i++) begin
            #1;
            checks++; if (carry_a !== (ma == 59)) begin failures++; $display("FAIL up_carry cyc=%0d got=%b exp=%b", i, carry_a, ma == 59); end
            tick();
            checks++; if (cnt_a !== 6'((i + 1) % 60)) begin failures++; $display("FAIL up_cnt cyc=%0d got=%0d exp=%0d", i, cnt_a, (i + 1) % 60); end
            checks++; if (wrapped_a !== (i == 59)) begin failures++; $display("FAIL up_wrapped cyc=%0d got=%b exp=%b", i, wrapped_a, i == 59); end
`ifdef COUNTER_BCD_OUT_EN
            checks++; if (tens_a !== 4'(ma / 10) || ones_a !== 4'(ma % 10)) begin failures++; $display("FAIL up_bcd got=%0d/%0d exp=%0d/%0d", tens_a, ones_a, ma / 10, ma % 10); end
`endif
        end
    endtask

    task automatic test_lim_load();
        idle_inputs();
        lim_b = 6'd30; load_b = 1; lv_b = 6'd31;
        tick();
        checks++; if (cnt_b !== 6'd30) begin failures++; $display("FAIL load_clamp got=%0d exp=30", cnt_b); end
        load_b = 0; en_b = 1; up_b = 1;
        #1;
        checks++; if (carry_b !== 1'b1) begin failures++; $display("FAIL lim_carry got=%b exp=1", carry_b); end
        tick();
        checks++; if (cnt_b !== 6'd1) begin failures++; $display("FAIL lim_wrap_cnt got=%0d exp=1", cnt_b); end
        checks++; if (wrapped_b !== 1'b1) begin failures++; $display("FAIL lim_wrapped got=%b exp=1", wrapped_b); end
    endtask

    task automatic test_lim_drop();
        idle_inputs();
        lim_b = 6'd31; load_b = 1; lv_b = 6'd31;
        tick();
        load_b = 0; lim_b = 6'd28;
        tick();
        checks++; if (cnt_b !== 6'd31) begin failures++; $display("FAIL drop_hold got=%0d exp=31", cnt_b); end
        en_b = 1; up_b = 0;
        #1;
        checks++; if (borrow_b !== 1'b0) begin failures++; $display("FAIL drop_down_borrow got=%b exp=0", borrow_b); end
        tick();
        checks++; if (cnt_b !== 6'd28) begin failures++; $display("FAIL drop_down_cnt got=%0d exp=28", cnt_b); end
        checks++; if (wrapped_b !== 1'b0) begin failures++; $display("FAIL drop_down_wrapped got=%b exp=0", wrapped_b); end
        en_b = 0; lim_b = 6'd31; load_b = 1; lv_b = 6'd31;
        tick();
        load_b = 0; lim_b = 6'd28; en_b = 1; up_b = 1;
        #1;
        checks++; if (carry_b !== 1'b1) begin failures++; $display("FAIL drop_up_carry got=%b exp=1", carry_b); end
        tick();
        checks++; if (cnt_b !== 6'd1) begin failures++; $display("FAIL drop_up_cnt got=%0d exp=1", cnt_b); end
    endtask

    task automatic test_borrow_load();
        idle_inputs();
        load_a = 1; lv_a = 6'd0;
        tick();
        load_a = 0; en_a = 1; up_a = 0;
        #1;
        checks++; if (borrow_a !== 1'b1) begin failures++; $display("FAIL borrow_at_min got=%b exp=1", borrow_a); end
        tick();
        checks++; if (cnt_a !== 6'd59) begin failures++; $display("FAIL borrow_cnt got=%0d exp=59", cnt_a); end
        checks++; if (wrapped_a !== 1'b1) begin failures++; $display("FAIL borrow_wrapped got=%b exp=1", wrapped_a); end
        en_a = 0; load_a = 1; lv_a = 6'd0;
        tick();
        checks++; if (wrapped_a !== 1'b0) begin failures++; $display("FAIL wrapped_one_cycle got=%b exp=0", wrapped_a); end
        en_a = 1; up_a = 0; load_a = 1; lv_a = 6'd10;
        #1;
        checks++; if (borrow_a !== 1'b0) begin failures++; $display("FAIL load_masks_borrow got=%b exp=0", borrow_a); end
        tick();
        checks++; if (cnt_a !== 6'd10) begin failures++; $display("FAIL load_priority_cnt got=%0d exp=10", cnt_a); end
        checks++; if (wrapped_a !== 1'b0) begin failures++; $display("FAIL load_wrapped got=%b exp=0", wrapped_a); end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        lim_a = 6'd0; load_a = 1; lv_a = 6'd5;
        tick();
        checks++; if (cnt_a !== 6'd0) begin failures++; $display("FAIL b2b_load_clamp got=%0d exp=0", cnt_a); end
        load_a = 0; en_a = 1; up_a = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (wrapped_a !== 1'b1 || cnt_a !== 6'd0) begin failures++; $display("FAIL b2b_wrap cyc=%0d got=%b/%0d exp=1/0", i, wrapped_a, cnt_a); end
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        load_a = 1; lv_a = 6'd37;
        tick();
        checks++; if (cnt_a !== 6'd37) begin failures++; $display("FAIL pre_reset_cnt got=%0d exp=37", cnt_a); end
        load_a = 0; en_a = 1; up_a = 1;
        #2 rst = 1'b1;
        #1;
        checks++; if (cnt_a !== 6'd0) begin failures++; $display("FAIL async_reset_cnt got=%0d exp=0", cnt_a); end
        checks++; if (wrapped_a !== 1'b0) begin failures++; $display("FAIL async_reset_wrapped got=%b exp=0", wrapped_a); end
        #2 rst = 1'b0;
        ma = 0; mwa = 0; mb = 1; mwb = 0;
        tick();
        checks++; if (cnt_a !== 6'd1) begin failures++; $display("FAIL resume_after_reset got=%0d exp=1", cnt_a); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en_a = 1'($urandom); up_a = 1'($urandom); load_a = ($urandom_range(0, 7) == 0);
            lv_a = 6'($urandom_range(0, 63));
            lim_a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(50, 59));
            en_b = 1'($urandom); up_b = 1'($urandom); load_b = ($urandom_range(0, 7) == 0);
            lv_b = 6'($urandom_range(0, 63));
            lim_b = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(28, 31));
            #1;
            checks++; if (carry_a !== mcarry(ma, en_a, up_a, load_a, lim_a, 0, 59) || borrow_a !== mborrow(ma, en_a, up_a, load_a, 0)) begin
                failures++; $display("FAIL rnd_cb_a cyc=%0d got=%b%b cnt=%0d", i, carry_a, borrow_a, ma); end
            checks++; if (carry_b !== mcarry(mb, en_b, up_b, load_b, lim_b, 1, 31) || borrow_b !== mborrow(mb, en_b, up_b, load_b, 1)) begin
                failures++; $display("FAIL rnd_cb_b cyc=%0d got=%b%b cnt=%0d", i, carry_b, borrow_b, mb); end
            tick();
            checks++; if (cnt_a !== 6'(ma) || wrapped_a !== mwa) begin failures++; $display("FAIL rnd_a cyc=%0d got=%0d/%b exp=%0d/%b", i, cnt_a, wrapped_a, ma, mwa); end
            checks++; if (cnt_b !== 6'(mb) || wrapped_b !== mwb) begin failures++; $display("FAIL rnd_b cyc=%0d got=%0d/%b exp=%0d/%b", i, cnt_b, wrapped_b, mb, mwb); end
`ifdef COUNTER_BCD_OUT_EN
            checks++; if (tens_b !== 4'(mb / 10) || ones_b !== 4'(mb % 10)) begin failures++; $display("FAIL rnd_bcd_b got=%0d/%0d exp=%0d/%0d", tens_b, ones_b, mb / 10, mb % 10); end
`endif
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        ma = 0; mb = 1; mwa = 0; mwb = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_count_up_wrap();
        test_lim_load();
        test_lim_drop();
        test_borrow_load();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
